// File: rtl/rf_wb_arbiter.sv
// Shares the scalar regfile write port among writeback, divider and vector results,
// and keeps a busy scoreboard of registers awaiting long-latency writes.
module rf_wb_arbiter #(
    parameter int WORD_WIDTH   = 32,
    parameter int REGFILE_BITS = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    wb_en,
    input  logic [REGFILE_BITS-1:0] wb_rd,
    input  logic [WORD_WIDTH-1:0]   wb_data,
    output logic                    wb_stall,
    input  logic                    div_valid,
    output logic                    div_ready,
    input  logic [REGFILE_BITS-1:0] div_rd,
    input  logic [WORD_WIDTH-1:0]   div_data,
    input  logic                    vec_valid,
    output logic                    vec_ready,
    input  logic [REGFILE_BITS-1:0] vec_rd,
    input  logic [WORD_WIDTH-1:0]   vec_data,
    input  logic                    iss_div_en,
    input  logic                    iss_vec_en,
    input  logic [REGFILE_BITS-1:0] iss_rd,
    input  logic [REGFILE_BITS-1:0] chk_rs1,
    input  logic [REGFILE_BITS-1:0] chk_rs2,
    output logic                    rs1_busy,
    output logic                    rs2_busy,
    output logic                    rf_wr_en,
    output logic [REGFILE_BITS-1:0] rf_dest_addr,
    output logic [WORD_WIDTH-1:0]   rf_wr_data
);

    localparam int NUM_REGS = 1 << REGFILE_BITS;
    localparam int AGE_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    typedef struct packed {
        logic                    full;
        logic [REGFILE_BITS-1:0] rd;
        logic [WORD_WIDTH-1:0]   data;
        logic [AGE_W-1:0]        age;
    } hold_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WB,
        GNT_DIV,
        GNT_VEC
    } grant_e;

    hold_t               div_q, div_d;
    hold_t               vec_q, vec_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    grant_e              grant;
    logic                wb_cand, div_cand, vec_cand;
    logic                div_starved, vec_starved;

    // A new capture always wins over draining; an rd==0 entry empties without a grant.
    function automatic hold_t hold_next(input hold_t                   cur,
                                        input logic                    acc,
                                        input logic [REGFILE_BITS-1:0] rd,
                                        input logic [WORD_WIDTH-1:0]   data,
                                        input logic                    granted);
        hold_t nxt;
        nxt = cur;
        if (acc) begin
            nxt.full = 1'b1;
            nxt.rd   = rd;
            nxt.data = data;
            nxt.age  = '0;
        end else if (granted || (cur.full && cur.rd == '0)) begin
            nxt.full = 1'b0;
            nxt.age  = '0;
        end else if (cur.full && cur.age != AGE_MAX) begin
            nxt.age = cur.age + AGE_W'(1);
        end
        return nxt;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wb_cand     = wb_en && (wb_rd != '0);
        div_cand    = div_q.full && (div_q.rd != '0);
        vec_cand    = vec_q.full && (vec_q.rd != '0);
        div_starved = div_cand && (div_q.age >= AGE_MAX);
        vec_starved = vec_cand && (vec_q.age >= AGE_MAX);
        grant       = GNT_NONE;
        if (!nrst)            grant = GNT_NONE;
        else if (div_starved) grant = GNT_DIV;
        else if (vec_starved) grant = GNT_VEC;
        else if (wb_cand)     grant = GNT_WB;
        else if (div_cand)    grant = GNT_DIV;
        else if (vec_cand)    grant = GNT_VEC;
    end

    always_comb begin
        rf_wr_en     = 1'b0;
        rf_dest_addr = '0;
        rf_wr_data   = '0;
        case (grant)
            GNT_WB: begin
                rf_wr_en     = 1'b1;
                rf_dest_addr = wb_rd;
                rf_wr_data   = wb_data;
            end
            GNT_DIV: begin
                rf_wr_en     = 1'b1;
                rf_dest_addr = div_q.rd;
                rf_wr_data   = div_q.data;
            end
            GNT_VEC: begin
                rf_wr_en     = 1'b1;
                rf_dest_addr = vec_q.rd;
                rf_wr_data   = vec_q.data;
            end
            default: ;
        endcase
        wb_stall  = nrst && wb_cand && (grant != GNT_WB);
        div_ready = nrst && (!div_q.full || grant == GNT_DIV);
        vec_ready = nrst && (!vec_q.full || grant == GNT_VEC);
        rs1_busy  = nrst && busy_q[chk_rs1];
        rs2_busy  = nrst && busy_q[chk_rs2];
    end

    always_comb begin
        div_d  = hold_next(div_q, div_valid && div_ready, div_rd, div_data, grant == GNT_DIV);
        vec_d  = hold_next(vec_q, vec_valid && vec_ready, vec_rd, vec_data, grant == GNT_VEC);
        busy_d = busy_q;
        if (grant == GNT_DIV) busy_d[div_q.rd] = 1'b0;
        if (grant == GNT_VEC) busy_d[vec_q.rd] = 1'b0;
        // Applied after the clears so a same-cycle reissue to the same rd stays busy.
        if (iss_div_en || iss_vec_en) busy_d[iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            div_q  <= '0;
            vec_q  <= '0;
            busy_q <= '0;
        end else begin
            div_q  <= div_d;
            vec_q  <= vec_d;
            busy_q <= busy_d;
        end
    end

endmodule
